sgmii_reset_ctrl: RTL and testbench

- Reset and bring-up sequencer that drives the SGMII PHY's control side.
- Asserts and releases sgmii_txreset/sgmii_rxreset and enables comma alignment. Watches PHY status (pll_locked, resetdone, RX buffer error) and reports link_ready.
- Runs on the free-running local reference clock, so it keeps working while the PHY's recovered and user clocks are absent.

---
 rtl/sgmii_rst_pkg.sv | 36 +++
 rtl/sgmii_rst_sync.sv | 26 ++
 rtl/sgmii_reset_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sgmii_reset_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sgmii_rst_pkg.sv
// rtl/sgmii_rst_pkg.sv - shared states, constants and output decode for the SGMII reset sequencer
package sgmii_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    ASSERT_RST = 3'd1,
    WAIT_DONE  = 3'd2,
    READY      = 3'd3,
    RX_RECOVER = 3'd4
  } state_t;

  localparam int RETRY_W    = 8;
  localparam int SYNC_DEPTH = 2;
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  typedef struct packed {
    logic txreset;
    logic rxreset;
    logic encommaalign;
    logic link_ready;
  } ctrl_t;

  // PHY control levels owned by each state; unknown encodings look like WAIT_LOCK
  function automatic ctrl_t ctrl_outputs(input state_t s);
    ctrl_t c;
    c = '{txreset: 1'b1, rxreset: 1'b1, encommaalign: 1'b0, link_ready: 1'b0};
    case (s)
      WAIT_DONE:  c = '{txreset: 1'b0, rxreset: 1'b0, encommaalign: 1'b1, link_ready: 1'b0};
      READY:      c = '{txreset: 1'b0, rxreset: 1'b0, encommaalign: 1'b1, link_ready: 1'b1};
      RX_RECOVER: c = '{txreset: 1'b0, rxreset: 1'b1, encommaalign: 1'b0, link_ready: 1'b0};
      default:    c = '{txreset: 1'b1, rxreset: 1'b1, encommaalign: 1'b0, link_ready: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sgmii_rst_sync.sv
// rtl/sgmii_rst_sync.sv - multi-flop synchronizer with async reset to zero
module sgmii_rst_sync
  import sgmii_rst_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             mgt_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_DEPTH-1:0][WIDTH-1:0] stage;

  // shift the raw inputs through the synchronizer chain
  always_ff @(posedge clk or posedge mgt_reset) begin
    if (mgt_reset) begin
      stage <= '0;
    end else begin
      stage <= {stage[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = stage[SYNC_DEPTH-1];

endmodule

// File: rtl/sgmii_reset_ctrl.sv
// rtl/sgmii_reset_ctrl.sv - SGMII PHY reset/bring-up sequencer; SGMII_RST_ELECIDLE_EN enables elecidle-triggered RX recovery
module sgmii_reset_ctrl
  import sgmii_rst_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RST_HOLD     = 16,
  parameter int DONE_TIMEOUT = 65536,
  parameter int IDLE_FILTER  = 1024
) (
  input  logic               clk_ds_i,
  input  logic               mgt_reset,
  input  logic               pll_locked,
  input  logic               resetdone,
  input  logic               rxbuf_err,
  input  logic               elecidle,
  output logic               sgmii_txreset,
  output logic               sgmii_rxreset,
  output logic               sgmii_encommaalign,
  output logic               link_ready,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state_o
);

  localparam int MAX_A     = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
  localparam int MAX_B     = (RST_HOLD > IDLE_FILTER) ? RST_HOLD : IDLE_FILTER;
  localparam int MAX_PARAM = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W     = $clog2(MAX_PARAM) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             retry_inc;
  logic             idle_hit;
  logic [2:0]       sync_q;
  logic             lock_s, done_s, rxbuf_s;
  ctrl_t            ctrl_next;

  sgmii_rst_sync #(.WIDTH(3)) u_status_sync (
    .clk       (clk_ds_i),
    .mgt_reset (mgt_reset),
    .d         ({pll_locked, resetdone, rxbuf_err}),
    .q         (sync_q)
  );

  assign lock_s  = sync_q[2];
  assign done_s  = sync_q[1];
  assign rxbuf_s = sync_q[0];

`ifdef SGMII_RST_ELECIDLE_EN
  localparam int IDLE_W = $clog2(IDLE_FILTER) + 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_FILTER - 1);

  logic              idle_s;
  logic [IDLE_W-1:0] idle_cnt;

  sgmii_rst_sync #(.WIDTH(1)) u_idle_sync (
    .clk       (clk_ds_i),
    .mgt_reset (mgt_reset),
    .d         (elecidle),
    .q         (idle_s)
  );

  assign idle_hit = idle_s && (idle_cnt == IDLE_LAST);

  // run of consecutive elecidle cycles, only meaningful while the link is up
  always_ff @(posedge clk_ds_i or posedge mgt_reset) begin
    if (mgt_reset) begin
      idle_cnt <= '0;
    end else if (state != READY || !idle_s || idle_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  logic unused_elecidle;
  assign unused_elecidle = elecidle;
  assign idle_hit        = 1'b0;
`endif

  // next state, retry bookkeeping; lock loss overrides every other decision
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    retry_inc  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ASSERT_RST;
        end else if (cnt == LOCK_LAST) begin
          retry_inc = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      ASSERT_RST: begin
        if (cnt == HOLD_LAST) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_s) begin
          state_next = READY;
        end else if (cnt == DONE_LAST) begin
          state_next = ASSERT_RST;
          retry_inc  = 1'b1;
        end
      end
      READY: begin
        if (rxbuf_s) begin
          state_next = RX_RECOVER;
        end else if (!done_s) begin
          state_next = ASSERT_RST;
          retry_inc  = 1'b1;
        end else if (idle_hit) begin
          state_next = RX_RECOVER;
        end
      end
      RX_RECOVER: begin
        if (cnt == HOLD_LAST) state_next = WAIT_DONE;
      end
      default: state_next = WAIT_LOCK;
    endcase
    if (!lock_s && (state inside {ASSERT_RST, WAIT_DONE, READY, RX_RECOVER})) begin
      state_next = WAIT_LOCK;
      retry_inc  = 1'b1;
    end
  end

  assign ctrl_next = ctrl_outputs(state_next);

  // state register with outputs decoded from the state being entered
  always_ff @(posedge clk_ds_i or posedge mgt_reset) begin
    if (mgt_reset) begin
      state              <= WAIT_LOCK;
      sgmii_txreset      <= 1'b1;
      sgmii_rxreset      <= 1'b1;
      sgmii_encommaalign <= 1'b0;
      link_ready         <= 1'b0;
    end else begin
      state              <= state_next;
      sgmii_txreset      <= ctrl_next.txreset;
      sgmii_rxreset      <= ctrl_next.rxreset;
      sgmii_encommaalign <= ctrl_next.encommaalign;
      link_ready         <= ctrl_next.link_ready;
    end
  end

  // shared dwell/timeout counter, restarted on every state change; idle in READY
  always_ff @(posedge clk_ds_i or posedge mgt_reset) begin
    if (mgt_reset) begin
      cnt <= '0;
    end else if (cnt_clr || state_next != state || state == READY) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // saturating count of timeouts and lock losses
  always_ff @(posedge clk_ds_i or posedge mgt_reset) begin
    if (mgt_reset) begin
      retry_count <= '0;
    end else if (retry_inc && retry_count != RETRY_MAX) begin
      retry_count <= retry_count + 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_sgmii_reset_ctrl.sv
// tb/tb_sgmii_reset_ctrl.sv - scoreboard bench for sgmii_reset_ctrl
module tb_sgmii_reset_ctrl;

  logic       clk_ds_i = 1'b0;
  logic       mgt_reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       resetdone = 1'b0;
  logic       rxbuf_err = 1'b0;
  logic       elecidle = 1'b0;
  logic       sgmii_txreset, sgmii_rxreset, sgmii_encommaalign, link_ready;
  logic [7:0] retry_count;
  logic [2:0] state_o;

  sgmii_reset_ctrl #(
    .LOCK_TIMEOUT (64),
    .RST_HOLD     (8),
    .DONE_TIMEOUT (32),
    .IDLE_FILTER  (16)
  ) dut (
    .clk_ds_i           (clk_ds_i),
    .mgt_reset          (mgt_reset),
    .pll_locked         (pll_locked),
    .resetdone          (resetdone),
    .rxbuf_err          (rxbuf_err),
    .elecidle           (elecidle),
    .sgmii_txreset      (sgmii_txreset),
    .sgmii_rxreset      (sgmii_rxreset),
    .sgmii_encommaalign (sgmii_encommaalign),
    .link_ready         (link_ready),
    .retry_count        (retry_count),
    .state_o            (state_o)
  );

  always #5 clk_ds_i = ~clk_ds_i;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] st;
    logic       tx;
    logic       rx;
    logic       ca;
    logic       lr;
    logic [7:0] rc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   base = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk_ds_i) cyc <= cyc + 1;

  task automatic ex(input int k, input string nm, input logic [2:0] st, input logic tx,
                    input logic rx, input logic ca, input logic lr, input logic [7:0] rc);
    exp_t r;
    r.cyc = base + k; r.name = nm; r.st = st; r.tx = tx; r.rx = rx;
    r.ca = ca; r.lr = lr; r.rc = rc;
    sb.push_back(r);
  endtask

  task automatic wait_k(input int k);
    while (cyc < base + k) @(negedge clk_ds_i);
  endtask

  always @(negedge clk_ds_i) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expected at cycle %0d, reached at %0d", e.name, e.cyc, cyc);
      end else if ({state_o, sgmii_txreset, sgmii_rxreset, sgmii_encommaalign, link_ready, retry_count}
                   !== {e.st, e.tx, e.rx, e.ca, e.lr, e.rc}) begin
        n_fail++;
        $display("FAIL %s @%0d: got st=%0d tx=%b rx=%b ca=%b lr=%b rc=%0d, want st=%0d tx=%b rx=%b ca=%b lr=%b rc=%0d",
                 e.name, cyc, state_o, sgmii_txreset, sgmii_rxreset, sgmii_encommaalign, link_ready,
                 retry_count, e.st, e.tx, e.rx, e.ca, e.lr, e.rc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ex(1, "reset_vals", 3'd0, 1, 1, 0, 0, 8'd0);
    @(posedge clk_ds_i); @(posedge clk_ds_i); #1;
    mgt_reset = 1'b0;
    base = cyc;

    ex(12,  "lock_wait",     3'd0, 1, 1, 0, 0, 8'd0);
    ex(13,  "assert_rst",    3'd1, 1, 1, 0, 0, 8'd0);
    ex(20,  "hold_last",     3'd1, 1, 1, 0, 0, 8'd0);
    ex(21,  "resets_fall",   3'd2, 0, 0, 1, 0, 8'd0);
    ex(27,  "done_sync",     3'd2, 0, 0, 1, 0, 8'd0);
    ex(28,  "link_up",       3'd3, 0, 0, 1, 1, 8'd0);
    ex(37,  "rxerr_sync",    3'd3, 0, 0, 1, 1, 8'd0);
    ex(38,  "rx_recover",    3'd4, 0, 1, 0, 0, 8'd0);
    ex(45,  "rx_hold_last",  3'd4, 0, 1, 0, 0, 8'd0);
    ex(46,  "rx_wait_done",  3'd2, 0, 0, 1, 0, 8'd0);
    ex(47,  "rx_relink",     3'd3, 0, 0, 1, 1, 8'd0);
    ex(70,  "idle15_ready",  3'd3, 0, 0, 1, 1, 8'd0);
`ifdef SGMII_RST_ELECIDLE_EN
    ex(94,  "idle16_recov",  3'd4, 0, 1, 0, 0, 8'd0);
`else
    ex(94,  "idle16_ready",  3'd3, 0, 0, 1, 1, 8'd0);
`endif
    ex(105, "idle_after",    3'd3, 0, 0, 1, 1, 8'd0);
    ex(112, "done_drop_syn", 3'd3, 0, 0, 1, 1, 8'd0);
    ex(113, "done_drop",     3'd1, 1, 1, 0, 0, 8'd1);
    ex(121, "redo_wait",     3'd2, 0, 0, 1, 0, 8'd1);
    ex(152, "pre_lockloss",  3'd2, 0, 0, 1, 0, 8'd1);
    ex(153, "lockloss_tmo",  3'd0, 1, 1, 0, 0, 8'd2);
    ex(163, "relock",        3'd1, 1, 1, 0, 0, 8'd2);
    ex(171, "relock_wait",   3'd2, 0, 0, 1, 0, 8'd2);
    ex(175, "async_reset",   3'd0, 1, 1, 0, 0, 8'd0);

    wait_k(10);  pll_locked = 1'b1;
    wait_k(25);  resetdone  = 1'b1;
    wait_k(35);  rxbuf_err  = 1'b1;
    wait_k(36);  rxbuf_err  = 1'b0;
    wait_k(50);  elecidle   = 1'b1;
    wait_k(65);  elecidle   = 1'b0;
    wait_k(75);  elecidle   = 1'b1;
    wait_k(91);  elecidle   = 1'b0;
    wait_k(110); resetdone  = 1'b0;
    wait_k(150); pll_locked = 1'b0;
    wait_k(160); pll_locked = 1'b1;
    wait_k(174);
    @(posedge clk_ds_i); #1;
    mgt_reset  = 1'b1;
    pll_locked = 1'b0;
    resetdone  = 1'b0;
    @(posedge clk_ds_i); @(posedge clk_ds_i); #1;
    mgt_reset = 1'b0;
    base = cyc;

    ex(63,    "lock_tmo_pre",  3'd0, 1, 1, 0, 0, 8'd0);
    ex(64,    "lock_tmo_1",    3'd0, 1, 1, 0, 0, 8'd1);
    ex(128,   "lock_tmo_2",    3'd0, 1, 1, 0, 0, 8'd2);
    ex(200,   "lock_tmo_3",    3'd0, 1, 1, 0, 0, 8'd3);
    ex(203,   "dt_assert",     3'd1, 1, 1, 0, 0, 8'd3);
    ex(211,   "dt_wait",       3'd2, 0, 0, 1, 0, 8'd3);
    ex(242,   "dt_last",       3'd2, 0, 0, 1, 0, 8'd3);
    ex(243,   "dt_timeout",    3'd1, 1, 1, 0, 0, 8'd4);
    ex(251,   "dt_wait2",      3'd2, 0, 0, 1, 0, 8'd4);
    ex(10282, "sat_pre",       3'd2, 0, 0, 1, 0, 8'd254);
    ex(10283, "sat_255",       3'd1, 1, 1, 0, 0, 8'd255);
    ex(10443, "sat_hold",      3'd1, 1, 1, 0, 0, 8'd255);

    wait_k(200); pll_locked = 1'b1;
    wait_k(10450);
    repeat (4) @(negedge clk_ds_i);

    if (sb.size() != 0) begin
      n_checks += sb.size();
      n_fail   += sb.size();
      $display("FAIL scoreboard: %0d expectations never checked", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
